nios2_jtag_dbg_cmd_bridge: RTL and testbench

//  Parametrised successor to the Nios II JTAG debug wrapper datapath. Takes virtual-JTAG state strobes,

---
 rtl/nios2_jtag_dbg_pkg.sv | 21 ++
 rtl/nios2_jtag_dbg_shreg.sv | 65 ++++++
 rtl/nios2_jtag_dbg_cmd_bridge.sv | 179 +++++++++++++++++
 tb/tb_nios2_jtag_dbg_cmd_bridge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_jtag_dbg_pkg.sv
// Shared definitions for the Nios II JTAG debug command bridge.
//   dbg_state_e  : bridge FSM states (idle, shifting a scan, command pending)
//   action_bit() : bit offset of the take_action flag inside a DR_W-wide scan
//   parity_bit() : bit offset of the optional even-parity bit inside a scan
package nios2_jtag_dbg_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StPend  = 2'd2
  } dbg_state_e;

  function automatic int unsigned action_bit(input int unsigned dr_w);
    return dr_w - 1;
  endfunction

  function automatic int unsigned parity_bit(input int unsigned dr_w);
    return dr_w - 2;
  endfunction

endpackage

// File: rtl/nios2_jtag_dbg_shreg.sv
// Capture mux, DR shift register and registered TDO for the JTAG debug bridge.
// Ports:
//   i_clk, i_reset : system clock, synchronous active-high reset
//   i_cap          : load the shift register from the selected channel's capture word
//   i_shift        : shift one bit in from i_tdi at the MSB, LSB drops out
//   i_sel          : channel select (latched IR)
//   i_cap_data     : per-channel capture words, channel k at [k*DR_W +: DR_W]
//   i_tdi          : serial data in
//   o_sr           : current shift register contents
//   o_tdo          : registered copy of the shift register LSB
module nios2_jtag_dbg_shreg #(
  parameter int unsigned IR_W = 2,
  parameter int unsigned DR_W = 38,
  localparam int unsigned N_CH = 2 ** IR_W
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cap,
  input  logic                 i_shift,
  input  logic [IR_W-1:0]      i_sel,
  input  logic [N_CH*DR_W-1:0] i_cap_data,
  input  logic                 i_tdi,
  output logic [DR_W-1:0]      o_sr,
  output logic                 o_tdo
);

  logic [DR_W-1:0] r_sr;
  logic            r_tdo;
  logic [DR_W-1:0] w_cap;
  logic [DR_W-1:0] w_sr_d;

  always_comb begin
    w_cap = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (i_sel == IR_W'(k)) begin
        w_cap = i_cap_data[k*DR_W +: DR_W];
      end
    end
  end

  // Shift wins over capture if both are requested.
  always_comb begin
    w_sr_d = r_sr;
    if (i_shift) begin
      w_sr_d = {i_tdi, r_sr[DR_W-1:1]};
    end else if (i_cap) begin
      w_sr_d = w_cap;
    end
  end

  // TDO follows the new LSB so that it is valid as soon as the capture or shift lands.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sr  <= '0;
      r_tdo <= 1'b0;
    end else begin
      r_sr  <= w_sr_d;
      r_tdo <= w_sr_d[0];
    end
  end

  assign o_sr  = r_sr;
  assign o_tdo = r_tdo;

endmodule

// File: rtl/nios2_jtag_dbg_cmd_bridge.sv
// Nios II JTAG debug command bridge.
// Turns synchronised virtual-JTAG state strobes into a capture/shift DR datapath and issues
// one decoded command per completed scan on a valid/ready handshake.
// Optional feature macro: JTAG_DBG_PARITY_EN (even-parity check on each scan at update-DR).
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   ir_in, vs_uir       : virtual IR value, latched on the update-IR pulse
//   vs_cdr/sdr/udr      : capture-DR, shift-DR (one bit each), update-DR pulses
//   jtag_state_rti      : TAP in Run-Test/Idle; st_ready_test_idle is it delayed by 1 cycle
//   tdi, tdo            : serial scan data in / out
//   cap_data            : per-channel capture values
//   cmd_valid/cmd_ready : command handshake; cmd_ch, cmd_action, jdo describe the command
//   overrun             : sticky, an update-DR arrived while a command was still pending
//   parity_err          : sticky, a scan failed its parity check (0 when the check is absent)
module nios2_jtag_dbg_cmd_bridge
  import nios2_jtag_dbg_pkg::*;
#(
  parameter int unsigned IR_W = 2,
  parameter int unsigned DR_W = 38,
  localparam int unsigned N_CH = 2 ** IR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IR_W-1:0]      ir_in,
  input  logic                 vs_uir,
  input  logic                 vs_cdr,
  input  logic                 vs_sdr,
  input  logic                 vs_udr,
  input  logic                 jtag_state_rti,
  input  logic                 tdi,
  output logic                 tdo,
  input  logic [N_CH*DR_W-1:0] cap_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [IR_W-1:0]      cmd_ch,
  output logic                 cmd_action,
  output logic [DR_W-1:0]      jdo,
  output logic                 st_ready_test_idle,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int unsigned ACT_BIT = action_bit(DR_W);

  dbg_state_e      r_state, w_state_d;
  logic [IR_W-1:0] r_ir_lat;
  logic [DR_W-1:0] r_jdo;
  logic [IR_W-1:0] r_cmd_ch;
  logic            r_cmd_action;
  logic            r_rti;
  logic            r_overrun;
  logic            r_parity_err;

  logic            w_uir, w_cdr, w_sdr, w_udr;
  logic            w_hs;
  logic            w_load;
  logic            w_ovr_set;
  logic            w_par_set;
  logic            w_par_ok;
  logic [DR_W-1:0] w_sr;

  // Only the highest-priority strobe of a cycle takes effect: udr > sdr > cdr > uir.
  assign w_udr = vs_udr;
  assign w_sdr = vs_sdr & ~vs_udr;
  assign w_cdr = vs_cdr & ~vs_sdr & ~vs_udr;
  assign w_uir = vs_uir & ~vs_cdr & ~vs_sdr & ~vs_udr;

  assign w_hs = (r_state == StPend) & cmd_ready;

  nios2_jtag_dbg_shreg #(
    .IR_W (IR_W),
    .DR_W (DR_W)
  ) u_shreg (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_cap      (w_cdr),
    .i_shift    (w_sdr),
    .i_sel      (r_ir_lat),
    .i_cap_data (cap_data),
    .i_tdi      (tdi),
    .o_sr       (w_sr),
    .o_tdo      (tdo)
  );

`ifdef JTAG_DBG_PARITY_EN
  localparam int unsigned PAR_BIT = parity_bit(DR_W);
  // Even parity over the payload bits plus the action bit.
  assign w_par_ok = (w_sr[PAR_BIT] == ^{w_sr[ACT_BIT], w_sr[PAR_BIT-1:0]});
`else
  assign w_par_ok = 1'b1;
`endif

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    w_ovr_set = 1'b0;
    w_par_set = 1'b0;
    case (r_state)
      StIdle: begin
        // An update-DR with no capture before it is ignored.
        if (w_cdr) w_state_d = StShift;
      end
      StShift: begin
        if (w_udr) begin
          if (w_par_ok) begin
            w_load    = 1'b1;
            w_state_d = StPend;
          end else begin
            w_par_set = 1'b1;
            w_state_d = StIdle;
          end
        end
      end
      StPend: begin
        if (w_udr && !w_hs) begin
          // Keep the pending command, drop the new scan.
          w_ovr_set = 1'b1;
        end else if (w_udr) begin
          // Handshake and update in the same cycle: next command goes straight out.
          if (w_par_ok) begin
            w_load = 1'b1;
          end else begin
            w_par_set = 1'b1;
            w_state_d = StIdle;
          end
        end else if (w_hs) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_ir_lat     <= '0;
      r_jdo        <= '0;
      r_cmd_ch     <= '0;
      r_cmd_action <= 1'b0;
      r_rti        <= 1'b0;
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_rti   <= jtag_state_rti;
      if (w_uir) r_ir_lat <= ir_in;
      if (w_load) begin
        r_jdo        <= w_sr;
        r_cmd_ch     <= r_ir_lat;
        r_cmd_action <= w_sr[ACT_BIT];
      end
      r_overrun    <= r_overrun | w_ovr_set;
      r_parity_err <= r_parity_err | w_par_set;
    end
  end

  // Simulation-only check on the strobe protocol.
  always @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0({vs_uir, vs_cdr, vs_sdr, vs_udr}))
        else $error("nios2_jtag_dbg_cmd_bridge: more than one JTAG state strobe in a cycle");
    end
  end

  assign cmd_valid          = (r_state == StPend);
  assign cmd_ch             = r_cmd_ch;
  assign cmd_action         = r_cmd_action;
  assign jdo                = r_jdo;
  assign st_ready_test_idle = r_rti;
  assign overrun            = r_overrun;
`ifdef JTAG_DBG_PARITY_EN
  assign parity_err         = r_parity_err;
`else
  // Without the check no scan can fail, so the sticky register never sets.
  assign parity_err         = r_parity_err & 1'b0;
`endif

endmodule

// File: tb/tb_nios2_jtag_dbg_cmd_bridge.sv
// Self-checking bench for nios2_jtag_dbg_cmd_bridge: directed scenarios followed by random
// strobe traffic, all checked against a transaction-level model of the bridge.
module tb_nios2_jtag_dbg_cmd_bridge;

  localparam int unsigned IR_W = 2;
  localparam int unsigned DR_W = 38;
  localparam int unsigned N_CH = 4;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_UIR  = 4'b0001;
  localparam logic [3:0] OP_CDR  = 4'b0010;
  localparam logic [3:0] OP_SDR  = 4'b0100;
  localparam logic [3:0] OP_UDR  = 4'b1000;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [IR_W-1:0]      ir_in = '0;
  logic                 vs_uir = 1'b0, vs_cdr = 1'b0, vs_sdr = 1'b0, vs_udr = 1'b0;
  logic                 jtag_state_rti = 1'b0;
  logic                 tdi = 1'b0;
  logic                 tdo;
  logic [N_CH*DR_W-1:0] cap_data = '0;
  logic                 cmd_valid;
  logic                 cmd_ready = 1'b0;
  logic [IR_W-1:0]      cmd_ch;
  logic                 cmd_action;
  logic [DR_W-1:0]      jdo;
  logic                 st_ready_test_idle;
  logic                 overrun;
  logic                 parity_err;

  nios2_jtag_dbg_cmd_bridge #(
    .IR_W (IR_W),
    .DR_W (DR_W)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .ir_in              (ir_in),
    .vs_uir             (vs_uir),
    .vs_cdr             (vs_cdr),
    .vs_sdr             (vs_sdr),
    .vs_udr             (vs_udr),
    .jtag_state_rti     (jtag_state_rti),
    .tdi                (tdi),
    .tdo                (tdo),
    .cap_data           (cap_data),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_ch             (cmd_ch),
    .cmd_action         (cmd_action),
    .jdo                (jdo),
    .st_ready_test_idle (st_ready_test_idle),
    .overrun            (overrun),
    .parity_err         (parity_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the scan in flight, the latched IR and the pending command.
  logic [DR_W-1:0] m_cap [N_CH];
  logic [DR_W-1:0] m_sr;
  logic [IR_W-1:0] m_ir;
  logic            m_scan;   // a capture has started a scan that no update has consumed
  logic            m_pend;
  logic [DR_W-1:0] m_jdo;
  logic [IR_W-1:0] m_ch;
  logic            m_act;
  logic            m_ovr;
  logic            m_par;
  logic            m_rti;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

`ifdef JTAG_DBG_PARITY_EN
  function automatic logic scan_bad(input logic [DR_W-1:0] v);
    return ^v;  // parity bit included: even parity means the whole word XORs to 0
  endfunction
  function automatic logic [DR_W-1:0] fixp(input logic [DR_W-1:0] v);
    logic [DR_W-1:0] r;
    r = v;
    r[DR_W-2] = 1'b0;
    r[DR_W-2] = ^r;
    return r;
  endfunction
`else
  function automatic logic scan_bad(input logic [DR_W-1:0] v);
    return (v != v);
  endfunction
  function automatic logic [DR_W-1:0] fixp(input logic [DR_W-1:0] v);
    return v;
  endfunction
`endif

  task automatic drive_caps();
    for (int k = 0; k < int'(N_CH); k++) cap_data[k*DR_W +: DR_W] = m_cap[k];
  endtask

  task automatic model_reset();
    m_sr = '0; m_ir = '0; m_scan = 1'b0; m_pend = 1'b0;
    m_jdo = '0; m_ch = '0; m_act = 1'b0; m_ovr = 1'b0; m_par = 1'b0; m_rti = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk_eq({tag, "_valid"}, 64'(cmd_valid), 64'(m_pend));
    chk_eq({tag, "_tdo"}, 64'(tdo), 64'(m_sr[0]));
    chk_eq({tag, "_ovr"}, 64'(overrun), 64'(m_ovr));
    chk_eq({tag, "_par"}, 64'(parity_err), 64'(m_par));
    chk_eq({tag, "_rti"}, 64'(st_ready_test_idle), 64'(m_rti));
    if (m_pend) begin
      chk_eq({tag, "_jdo"}, 64'(jdo), 64'(m_jdo));
      chk_eq({tag, "_ch"}, 64'(cmd_ch), 64'(m_ch));
      chk_eq({tag, "_act"}, 64'(cmd_action), 64'(m_act));
    end
  endtask

  // One clock cycle with (at most) one strobe; called at a negedge, returns at the next.
  task automatic step(input logic [3:0] op, input string tag);
    logic hs;
    vs_uir = op[0]; vs_cdr = op[1]; vs_sdr = op[2]; vs_udr = op[3];
    jtag_state_rti = 1'($urandom_range(0, 1));
    drive_caps();
    hs = m_pend && cmd_ready;
    if (op[3]) begin
      if (m_pend && !hs) begin
        m_ovr = 1'b1;
      end else if (m_pend || m_scan) begin
        if (scan_bad(m_sr)) begin
          m_par  = 1'b1;
          m_pend = 1'b0;
        end else begin
          m_jdo = m_sr; m_ch = m_ir; m_act = m_sr[DR_W-1]; m_pend = 1'b1;
        end
        m_scan = 1'b0;
      end
    end else begin
      if (op[1] && !m_pend) m_scan = 1'b1;
      if (hs) m_pend = 1'b0;
      if (op[2]) m_sr = {tdi, m_sr[DR_W-1:1]};
      else if (op[1]) m_sr = m_cap[m_ir];
      else if (op[0]) m_ir = ir_in;
    end
    m_rti = jtag_state_rti;
    @(negedge clk);
    vs_uir = 1'b0; vs_cdr = 1'b0; vs_sdr = 1'b0; vs_udr = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk_eq({tag, "_rst_valid"}, 64'(cmd_valid), 64'd0);
    chk_eq({tag, "_rst_tdo"}, 64'(tdo), 64'd0);
    chk_eq({tag, "_rst_jdo"}, 64'(jdo), 64'd0);
    chk_eq({tag, "_rst_ch"}, 64'(cmd_ch), 64'd0);
    chk_eq({tag, "_rst_act"}, 64'(cmd_action), 64'd0);
    chk_eq({tag, "_rst_ovr"}, 64'(overrun), 64'd0);
    chk_eq({tag, "_rst_par"}, 64'(parity_err), 64'd0);
    chk_eq({tag, "_rst_rti"}, 64'(st_ready_test_idle), 64'd0);
  endtask

  // Capture then shift in nbits of payload, LSB first.
  task automatic scan_in(input logic [DR_W-1:0] payload, input int nbits, input string tag);
    step(OP_CDR, tag);
    for (int i = 0; i < nbits; i++) begin
      tdi = payload[i];
      step(OP_SDR, tag);
    end
  endtask

  logic [DR_W-1:0] pa, pb;

  initial begin
    for (int k = 0; k < int'(N_CH); k++) m_cap[k] = DR_W'({$urandom(), $urandom()});
    drive_caps();
    repeat (2) @(negedge clk);
    do_reset("init");

    // 1: capture from channel 1 and stream it out on tdo
    m_cap[1] = 38'h2A_5555_AAAA;
    ir_in = 2'd1;
    step(OP_UIR, "t1");
    step(OP_CDR, "t1");
    pa = 38'h2A_5555_AAAA;
    for (int i = 0; i < int'(DR_W); i++) begin
      chk_eq("t1_stream", 64'(tdo), 64'(pa[i]));
      tdi = 1'b0;
      step(OP_SDR, "t1");
    end

    // 2: a full scan becomes a one-cycle command with the consumer ready
    pa = fixp(38'h20_0000_1234);
    cmd_ready = 1'b1;
    scan_in(pa, DR_W, "t2");
    step(OP_UDR, "t2");
    chk_eq("t2_valid", 64'(cmd_valid), 64'd1);
    chk_eq("t2_ch", 64'(cmd_ch), 64'd1);
    chk_eq("t2_act", 64'(cmd_action), 64'd1);
    chk_eq("t2_jdo", 64'(jdo), 64'(pa));
    step(OP_NONE, "t2");
    chk_eq("t2_drop", 64'(cmd_valid), 64'd0);

    // 3: consumer stalled across two scans -> overrun, first payload kept
    cmd_ready = 1'b0;
    pa = fixp(38'h11_2233_4455);
    pb = fixp(38'h05_6677_8899);
    scan_in(pa, DR_W, "t3");
    step(OP_UDR, "t3");
    scan_in(pb, DR_W, "t3");
    step(OP_UDR, "t3");
    chk_eq("t3_ovr", 64'(overrun), 64'd1);
    cmd_ready = 1'b1;
    chk_eq("t3_jdo", 64'(jdo), 64'(pa));
    step(OP_NONE, "t3");
    chk_eq("t3_done", 64'(cmd_valid), 64'd0);

    // 4: handshake coincides with the second update -> back-to-back commands
    do_reset("t4");
    cmd_ready = 1'b0;
    pa = fixp(38'h3F_0F0F_0F0F);
    pb = fixp(38'h01_F0F0_F0F0);
    scan_in(pa, DR_W, "t4");
    step(OP_UDR, "t4");
    scan_in(pb, DR_W, "t4");
    cmd_ready = 1'b1;
    step(OP_UDR, "t4");
    chk_eq("t4_valid", 64'(cmd_valid), 64'd1);
    chk_eq("t4_jdo", 64'(jdo), 64'(pb));
    chk_eq("t4_ovr", 64'(overrun), 64'd0);
    step(OP_NONE, "t4");
    chk_eq("t4_done", 64'(cmd_valid), 64'd0);

    // 5: reset in the middle of a scan, then a normal scan
    pa = fixp(38'h2B_DEAD_BEEF);
    scan_in(pa, 10, "t5");
    do_reset("t5");
    chk_eq("t5_valid", 64'(cmd_valid), 64'd0);
    chk_eq("t5_tdo", 64'(tdo), 64'd0);
    scan_in(pa, DR_W, "t5");
    step(OP_UDR, "t5");
    chk_eq("t5_jdo", 64'(jdo), 64'(pa));
    chk_eq("t5_ch", 64'(cmd_ch), 64'd0);
    step(OP_NONE, "t5");

`ifdef JTAG_DBG_PARITY_EN
    // 6: single-bit corruption is rejected, a clean scan goes through
    pa = fixp(38'h12_3456_789A);
    pb = pa;
    pb[3] = ~pb[3];
    scan_in(pb, DR_W, "t6");
    step(OP_UDR, "t6");
    chk_eq("t6_perr", 64'(parity_err), 64'd1);
    chk_eq("t6_nocmd", 64'(cmd_valid), 64'd0);
    scan_in(pa, DR_W, "t6");
    step(OP_UDR, "t6");
    chk_eq("t6_cmd", 64'(cmd_valid), 64'd1);
    chk_eq("t6_jdo", 64'(jdo), 64'(pa));
    step(OP_NONE, "t6");
`endif

    // Random strobe traffic
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      tdi = 1'($urandom_range(0, 1));
      cmd_ready = ($urandom_range(0, 3) != 0);
      ir_in = IR_W'($urandom());
      if (r == 99) begin
        for (int k = 0; k < int'(N_CH); k++) m_cap[k] = DR_W'({$urandom(), $urandom()});
      end
      if (r == 98) do_reset("rnd");
      else if (r < 4) step(OP_UIR, "rnd");
      else if (r < 10) step(OP_CDR, "rnd");
      else if (r < 16) step(OP_UDR, "rnd");
      else if (r < 75) step(OP_SDR, "rnd");
      else step(OP_NONE, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
